// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
package multicycle_pkg;

  localparam int unsigned WAIT_CNT_W = 8;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JAL      = 4'd11,
    S_ERROR    = 4'd12
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLI  = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_SLL  = 2'b10;
  localparam logic [1:0] ALU_ADDI = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_LINK = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts consecutive cycles spent waiting on memory; flags the cycle that would reach the limit.
module mem_wait_timer
  import multicycle_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic timeout_c
);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This waiting cycle brings the count up to the limit.
  assign timeout_c = en_i && (cnt_q == WAIT_CNT_W'(WAIT_LIMIT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: shares one ALU and one memory port across instruction phases.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       sign_or_zero,
  output logic       instr_done,
  output logic       mem_err,
  output logic [3:0] state_o
);

  state_t state_q;
  logic   in_wait;
  logic   wait_en;
  logic   wait_clr;
  logic   timeout;

  // The counter runs only while a memory access is outstanding; leaving or skipping a wait state clears it.
  assign in_wait  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign wait_en  = in_wait && !mem_ready;
  assign wait_clr = !in_wait || mem_ready;

  mem_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (wait_clr),
    .en_i      (wait_en),
    .timeout_c (timeout)
  );

  // State sequencing; mem_ready on the limit cycle takes the normal path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready)    state_q <= S_DECODE;
          else if (timeout) state_q <= S_ERROR;
        end
        S_DECODE: begin
          case (opcode)
            OP_ADD:          state_q <= S_EXEC_R;
            OP_SLI, OP_ADDI: state_q <= S_EXEC_I;
            OP_LW, OP_SW:    state_q <= S_MEM_ADDR;
            OP_BEQ:          state_q <= S_BRANCH;
            OP_J:            state_q <= S_JUMP;
            OP_JAL:          state_q <= S_JAL;
            default:         state_q <= S_FETCH;
          endcase
        end
        S_EXEC_R, S_EXEC_I: state_q <= S_WB_ALU;
        S_MEM_ADDR:         state_q <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: begin
          if (mem_ready)    state_q <= S_WB_MEM;
          else if (timeout) state_q <= S_ERROR;
        end
        S_MEM_WR: begin
          if (mem_ready)    state_q <= S_FETCH;
          else if (timeout) state_q <= S_ERROR;
        end
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL: state_q <= S_FETCH;
        S_ERROR:  state_q <= S_ERROR;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Moore strobe decode, forced to idle values while reset is held.
  always_comb begin
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_ALU;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = DST_RT;
    mem_to_reg   = WB_ALUOUT;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_REG;
    alu_op       = ALU_ADD;
    sign_or_zero = 1'b1;
    instr_done   = 1'b0;
    mem_err      = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_ONE;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = SRCB_IMM;
        S_EXEC_R: alu_src_a = 1'b1;
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          if (opcode == OP_SLI) begin
            alu_op       = ALU_SLL;
            sign_or_zero = 1'b0;
          end else begin
            alu_op = ALU_ADDI;
          end
        end
        S_WB_ALU: begin
          reg_write  = 1'b1;
          reg_dst    = (opcode == OP_ADD) ? DST_RD : DST_RT;
          instr_done = 1'b1;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_ADDI;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = WB_MDR;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_src     = PC_ALUOUT;
          pc_write   = zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_src     = PC_JUMP;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        S_JAL: begin
          pc_src     = PC_JUMP;
          pc_write   = 1'b1;
          reg_write  = 1'b1;
          reg_dst    = DST_LINK;
          mem_to_reg = WB_PC;
          instr_done = 1'b1;
        end
        S_ERROR: mem_err = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction cycle scripts built from the instruction phase rules.
module tb_multicycle_control;
  import multicycle_pkg::*;

  localparam int unsigned LIMIT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       ir_write, pc_write, i_or_d, mem_read, mem_write, reg_write;
  logic       alu_src_a, sign_or_zero, instr_done, mem_err;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  multicycle_control #(.WAIT_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .sign_or_zero(sign_or_zero), .instr_done(instr_done), .mem_err(mem_err), .state_o(state_o)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       ir_write, pc_write;
    logic [1:0] pc_src;
    logic       i_or_d, mem_read, mem_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       sign_or_zero, instr_done, mem_err;
  } exp_t;

  typedef struct {
    exp_t e;
    logic rdy;
    logic z;
  } rec_t;

  rec_t q[$];
  exp_t obs_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t blank(state_t s);
    exp_t e;
    e = '0;
    e.st = s;
    e.sign_or_zero = 1'b1;
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t e;
    e.st = state_o; e.ir_write = ir_write; e.pc_write = pc_write; e.pc_src = pc_src;
    e.i_or_d = i_or_d; e.mem_read = mem_read; e.mem_write = mem_write;
    e.reg_write = reg_write; e.reg_dst = reg_dst; e.mem_to_reg = mem_to_reg;
    e.alu_src_a = alu_src_a; e.alu_src_b = alu_src_b; e.alu_op = alu_op;
    e.sign_or_zero = sign_or_zero; e.instr_done = instr_done; e.mem_err = mem_err;
    return e;
  endfunction

  function automatic void push(exp_t e, logic rdy);
    rec_t r;
    r.e = e;
    r.rdy = rdy;
    r.z = 1'($urandom);
    q.push_back(r);
  endfunction

  // Expected cycle script for one instruction: df late fetch cycles, dm late data cycles.
  function automatic void build(logic [2:0] op, logic z, int df, int dm);
    exp_t e;
    for (int i = 0; i < df; i++) begin
      e = blank(S_FETCH); e.mem_read = 1'b1; e.alu_src_b = 2'b01;
      push(e, 1'b0);
    end
    e = blank(S_FETCH); e.mem_read = 1'b1; e.alu_src_b = 2'b01;
    e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(e, 1'b1);
    e = blank(S_DECODE); e.alu_src_b = 2'b10;
    push(e, 1'($urandom));
    case (op)
      OP_ADD, OP_SLI, OP_ADDI: begin
        e = blank(op == OP_ADD ? S_EXEC_R : S_EXEC_I); e.alu_src_a = 1'b1;
        if (op == OP_SLI) begin e.alu_src_b = 2'b10; e.alu_op = 2'b10; e.sign_or_zero = 1'b0; end
        if (op == OP_ADDI) begin e.alu_src_b = 2'b10; e.alu_op = 2'b11; end
        push(e, 1'($urandom));
        e = blank(S_WB_ALU); e.reg_write = 1'b1; e.instr_done = 1'b1;
        e.reg_dst = (op == OP_ADD) ? 2'b01 : 2'b00;
        push(e, 1'($urandom));
      end
      OP_LW, OP_SW: begin
        e = blank(S_MEM_ADDR); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b11;
        push(e, 1'($urandom));
        e = blank(op == OP_LW ? S_MEM_RD : S_MEM_WR); e.i_or_d = 1'b1;
        if (op == OP_LW) e.mem_read = 1'b1; else e.mem_write = 1'b1;
        for (int i = 0; i < dm; i++) push(e, 1'b0);
        if (op == OP_SW) e.instr_done = 1'b1;
        push(e, 1'b1);
        if (op == OP_LW) begin
          e = blank(S_WB_MEM); e.reg_write = 1'b1; e.mem_to_reg = 2'b01; e.instr_done = 1'b1;
          push(e, 1'($urandom));
        end
      end
      OP_BEQ: begin
        e = blank(S_BRANCH); e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01;
        e.pc_write = z; e.instr_done = 1'b1;
        push(e, 1'($urandom));
        q[q.size()-1].z = z;
      end
      default: begin
        e = blank(op == OP_J ? S_JUMP : S_JAL); e.pc_src = 2'b10; e.pc_write = 1'b1;
        e.instr_done = 1'b1;
        if (op == OP_JAL) begin e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; end
        push(e, 1'($urandom));
      end
    endcase
  endfunction

  function automatic int exp_latency(logic [2:0] op, int df, int dm);
    int base;
    case (op)
      OP_LW:               base = 5 + dm;
      OP_SW:               base = 4 + dm;
      OP_BEQ, OP_J, OP_JAL: base = 3;
      default:             base = 4;
    endcase
    return base + df;
  endfunction

  // Cycle index of the first instr_done and the number of done pulses observed.
  function automatic void done_stats(output int first, output int cnt);
    first = -1;
    cnt = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].instr_done === 1'b1) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
  endfunction

  // Drive the first n scripted cycles (entered just after a rising edge) and record outputs.
  task automatic run_queue(int n);
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      mem_ready = q[i].rdy;
      zero = q[i].z;
      @(negedge clk);
      obs_q.push_back(observe());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 3'b000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t o, x;
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = OP_JAL;
    x = blank(S_FETCH); x.st = '0;
    @(negedge clk);
    o = observe(); o.st = '0; checks++;
    if (o !== x) begin errors++; $display("FAIL reset_outputs: got %h expected %h", o, x); end
    @(posedge clk); #1;
    @(negedge clk);
    o = observe(); checks++;
    if (o.st !== 4'(S_FETCH)) begin errors++; $display("FAIL reset_state: got %0d expected %0d", o.st, S_FETCH); end
    o.st = '0; checks++;
    if (o !== x) begin errors++; $display("FAIL reset_hold: got %h expected %h", o, x); end
    @(posedge clk);
    #1 reset = 1'b0; mem_ready = 1'b0;
  endtask

  // Runs one full instruction, comparing every cycle and the overall latency.
  task automatic test_instr(string name, logic [2:0] op, logic z, int df, int dm);
    int first, cnt;
    q.delete();
    build(op, z, df, dm);
    opcode = op;
    run_queue(q.size());
    for (int i = 0; i < q.size(); i++) begin
      checks++;
      if (obs_q[i] !== q[i].e) begin
        errors++;
        $display("FAIL %s op=%0d cycle %0d: got %h expected %h", name, op, i, obs_q[i], q[i].e);
      end
    end
    done_stats(first, cnt);
    checks++;
    if (cnt != 1 || first + 1 != exp_latency(op, df, dm)) begin
      errors++;
      $display("FAIL %s_latency op=%0d: got done at %0d (pulses %0d) expected %0d", name, op, first + 1, cnt, exp_latency(op, df, dm));
    end
  endtask

  task automatic test_add();  test_instr("add", OP_ADD, 1'b0, 0, 0); endtask
  task automatic test_lw();   test_instr("lw_late", OP_LW, 1'b0, 0, 3); endtask
  task automatic test_beq();  test_instr("beq_taken", OP_BEQ, 1'b1, 0, 0); test_instr("beq_not", OP_BEQ, 1'b0, 0, 0); endtask
  task automatic test_jal();  test_instr("jal", OP_JAL, 1'b0, 0, 0); endtask

  task automatic test_timeout();
    exp_t e;
    q.delete();
    for (int i = 0; i < int'(LIMIT); i++) begin
      e = blank(S_FETCH); e.mem_read = 1'b1; e.alu_src_b = 2'b01;
      push(e, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      e = blank(S_ERROR); e.mem_err = 1'b1;
      push(e, 1'($urandom));
    end
    opcode = 3'($urandom);
    run_queue(q.size());
    for (int i = 0; i < q.size(); i++) begin
      checks++;
      if (obs_q[i] !== q[i].e) begin
        errors++;
        $display("FAIL timeout cycle %0d: got %h expected %h", i, obs_q[i], q[i].e);
      end
    end
    do_reset();
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_o !== 4'(S_FETCH) || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: state %0d mem_err %b expected state %0d mem_err 0", state_o, mem_err, S_FETCH);
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_reset_mid_sw();
    q.delete();
    build(OP_SW, 1'b0, 0, 3);
    opcode = OP_SW;
    run_queue(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_q[i] !== q[i].e) begin
        errors++;
        $display("FAIL sw_prefix cycle %0d: got %h expected %h", i, obs_q[i], q[i].e);
      end
    end
    reset = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b0 || instr_done !== 1'b0) begin
      errors++;
      $display("FAIL sw_reset_now: mem_write %b instr_done %b expected 0 0", mem_write, instr_done);
    end
    @(posedge clk);
    #1 reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_o !== 4'(S_FETCH) || mem_write !== 1'b0 || instr_done !== 1'b0) begin
      errors++;
      $display("FAIL sw_reset_next: state %0d mem_write %b instr_done %b expected %0d 0 0", state_o, mem_write, instr_done, S_FETCH);
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom);
      test_instr("random", op, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; opcode = 3'b000; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_add();
    test_lw();
    test_beq();
    test_jal();
    test_timeout();
    test_reset_mid_sw();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
